reg2reg_stim_chk: RTL

//  Initiator/checker for the 2-bit-in / 1-bit-out reg-to-reg AND pipeline.

---
 rtl/reg2reg_stim_chk_if.sv | 25 ++
 rtl/reg2reg_stim_chk.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/reg2reg_stim_chk_if.sv
// Stimulus/response and status bundle between the checker and its AND pipeline.
// slave = checker side, master = pipeline/controller side.
interface reg2reg_stim_chk_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             mode;
  logic [1:0]       drv;
  logic             rsp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport slave (
    input  start, mode, rsp,
    output drv, busy, done, pass, vec_cnt, err_cnt
  );

  modport master (
    output start, mode, rsp,
    input  drv, busy, done, pass, vec_cnt, err_cnt
  );
endinterface

// File: rtl/reg2reg_stim_chk.sv
// Drives counting/LFSR vectors into a 2-in/1-out AND pipeline and checks each
// response LAT+1 edges later, counting mismatches (saturating).
module reg2reg_stim_chk #(
  parameter int NUM_VEC = 16,
  parameter int LAT     = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  reg2reg_stim_chk_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [3:0]       LFSR_SEED = 4'b1001;
  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q;
  logic             mode_q;
  logic [3:0]       lfsr_q;
  logic [1:0]       drv_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  // Expected line: stage 0 loads alongside drv, stage LAT is compared with rsp.
  logic [LAT:0]     exp_vld_q;
  logic [LAT:0]     exp_bit_q;

  logic [1:0]       drv_d;
  logic             vld_d;
  logic [CNT_W-1:0] err_d;
  logic             last_cmp_d;

  function automatic logic [3:0] lfsr_step(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  always_comb begin
    drv_d = 2'b00;
    vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          drv_d = bus.mode ? LFSR_SEED[1:0] : 2'b00;
          vld_d = 1'b1;
        end else begin
          drv_d = 2'b00;
        end
      end
      RUN: begin
        if (vec_cnt_q != NUM_VEC_C) begin
          drv_d = mode_q ? lfsr_q[1:0] : vec_cnt_q[1:0];
          vld_d = 1'b1;
        end else begin
          drv_d = 2'b00;
        end
      end
      default: begin
        drv_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    err_d = err_cnt_q;
    if (exp_vld_q[LAT] && (bus.rsp != exp_bit_q[LAT]) && (err_cnt_q != CNT_MAX)) begin
      err_d = err_cnt_q + CNT_ONE;
    end else begin
      err_d = err_cnt_q;
    end
    // Drain entries are invalid, so a valid head with nothing valid behind it is the last vector.
    last_cmp_d = exp_vld_q[LAT] && (exp_vld_q[LAT-1:0] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      drv_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      exp_vld_q <= '0;
      exp_bit_q <= '0;
    end else begin
      drv_q     <= drv_d;
      exp_vld_q <= {exp_vld_q[LAT-1:0], vld_d};
      exp_bit_q <= {exp_bit_q[LAT-1:0], &drv_d};
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q    <= bus.mode;
            lfsr_q    <= lfsr_step(LFSR_SEED);
            vec_cnt_q <= CNT_ONE;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          err_cnt_q <= err_d;
          if (vec_cnt_q == NUM_VEC_C) begin
            state_q <= DRAIN;
          end else begin
            vec_cnt_q <= vec_cnt_q + CNT_ONE;
            lfsr_q    <= lfsr_step(lfsr_q);
          end
        end
        DRAIN: begin
          err_cnt_q <= err_d;
          if (last_cmp_d) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_d == '0);
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.drv     = drv_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.vec_cnt = vec_cnt_q;
  assign bus.err_cnt = err_cnt_q;

endmodule
